// File: rtl/game_pkg.sv
// Shared VGA timing defaults (1280x800) and the receiver lock-state encoding.
package game_pkg;
  localparam int   DEF_H_ACTIVE = 1280;
  localparam int   DEF_H_FP     = 72;
  localparam int   DEF_H_SYNC   = 128;
  localparam int   DEF_H_BP     = 200;
  localparam int   DEF_V_ACTIVE = 800;
  localparam int   DEF_V_FP     = 3;
  localparam int   DEF_V_SYNC   = 6;
  localparam int   DEF_V_BP     = 22;
  localparam logic DEF_HS_POL   = 1'b0;
  localparam logic DEF_VS_POL   = 1'b1;

  localparam logic [10:0] HCNT_MAX = 11'd2047;
  localparam logic [9:0]  VCNT_MAX = 10'd1023;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;
endpackage

// File: rtl/sync_edge_det.sv
// Registers one sync pin and flags the cycle it first shows the active level.
module sync_edge_det #(
  parameter logic POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic lead_o
);
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    sync_d = sync_in;
    prev_d = sync_q;
  end

  // Reset to the inactive level so a stream that starts in sync still yields an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= ~POL;
      prev_q <= ~POL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign lead_o = (sync_q == POL) && (prev_q != POL);
endmodule

// File: rtl/vga_rx_decoder.sv
// Recovers pixel coordinates and lock status from a VGA sync/colour stream.
// Pins are registered once, decoded outputs once more: two cycles pin-to-output.
module vga_rx_decoder
  import game_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = DEF_HS_POL,
  parameter logic VS_POL   = DEF_VS_POL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  pix_r,
  input  logic [3:0]  pix_g,
  input  logic [3:0]  pix_b,
  output logic [10:0] rx_x,
  output logic [9:0]  rx_y,
  output logic [3:0]  rx_r,
  output logic [3:0]  rx_g,
  output logic [3:0]  rx_b,
  output logic        rx_de,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] X_BEG  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] X_END  = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  Y_BEG  = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  Y_END  = 10'(V_SYNC + V_BP + V_ACTIVE);

  logic hs_lead, vs_lead;

  sync_edge_det #(.POL(HS_POL)) u_hs_det (
    .clk     (clk),
    .rst     (rst),
    .sync_in (hsync),
    .lead_o  (hs_lead)
  );

  sync_edge_det #(.POL(VS_POL)) u_vs_det (
    .clk     (clk),
    .rst     (rst),
    .sync_in (vsync),
    .lead_o  (vs_lead)
  );

  logic [11:0] pix_q, pix_d;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        vpend_q, vpend_d;
  rx_state_e   state_q, state_d;

  logic [10:0] rx_x_q, rx_x_d;
  logic [9:0]  rx_y_q, rx_y_d;
  logic [11:0] rx_rgb_q, rx_rgb_d;
  logic        rx_de_q, rx_de_d;
  logic        frame_start_q, frame_start_d;
  logic        locked_q, locked_d;
  logic        timing_err_q, timing_err_d;

  logic h_sat, mismatch, in_win;

  always_comb begin
    pix_d   = {pix_r, pix_g, pix_b};
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    vpend_d = vpend_q;

    // hcnt_d/vcnt_d are the coordinates of the sample now in the input registers.
    if (hs_lead) begin
      hcnt_d  = '0;
      vpend_d = 1'b0;
      if (vpend_q || vs_lead)      vcnt_d = '0;
      else if (vcnt_q != VCNT_MAX) vcnt_d = vcnt_q + 10'd1;
    end else begin
      if (hcnt_q != HCNT_MAX) hcnt_d = hcnt_q + 11'd1;
      if (vs_lead)            vpend_d = 1'b1;
    end

    h_sat    = !hs_lead && (hcnt_q == HCNT_MAX - 11'd1);
    mismatch = (hs_lead && (hcnt_q != H_LAST)) || h_sat ||
               (vs_lead && (vcnt_q != V_LAST));

    state_d      = state_q;
    timing_err_d = 1'b0;
    case (state_q)
      SEARCH: if (vs_lead) state_d = ALIGN;
      ALIGN: begin
        if (mismatch) begin
          state_d      = SEARCH;
          timing_err_d = 1'b1;
        end else if (vs_lead) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (mismatch) begin
          state_d      = SEARCH;
          timing_err_d = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase

    // Qualify with next state so the mismatch cycle already shows unlocked.
    in_win        = (hcnt_d >= X_BEG) && (hcnt_d < X_END) &&
                    (vcnt_d >= Y_BEG) && (vcnt_d < Y_END);
    locked_d      = (state_d == LOCKED);
    rx_de_d       = locked_d && in_win;
    rx_x_d        = rx_de_d ? hcnt_d - X_BEG : '0;
    rx_y_d        = rx_de_d ? vcnt_d - Y_BEG : '0;
    rx_rgb_d      = rx_de_d ? pix_q : '0;
    frame_start_d = rx_de_d && (hcnt_d == X_BEG) && (vcnt_d == Y_BEG);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q         <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      vpend_q       <= 1'b0;
      state_q       <= SEARCH;
      rx_x_q        <= '0;
      rx_y_q        <= '0;
      rx_rgb_q      <= '0;
      rx_de_q       <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      timing_err_q  <= 1'b0;
    end else begin
      pix_q         <= pix_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      vpend_q       <= vpend_d;
      state_q       <= state_d;
      rx_x_q        <= rx_x_d;
      rx_y_q        <= rx_y_d;
      rx_rgb_q      <= rx_rgb_d;
      rx_de_q       <= rx_de_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      timing_err_q  <= timing_err_d;
    end
  end

  assign rx_x        = rx_x_q;
  assign rx_y        = rx_y_q;
  assign rx_r        = rx_rgb_q[11:8];
  assign rx_g        = rx_rgb_q[7:4];
  assign rx_b        = rx_rgb_q[3:0];
  assign rx_de       = rx_de_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign timing_err  = timing_err_q;
endmodule

// File: tb/tb_vga_rx_decoder.sv
// Random VGA stream vs. a timestamp-based reference of the decoder rules, plus
// lock/relock, short line, hsync saturation, async reset and pixel injection cases.
module tb_vga_rx_decoder;
  localparam int   HA = 16, HF = 3, HSW = 4, HB = 5;
  localparam int   VA = 6,  VF = 1, VSW = 2, VB = 3;
  localparam logic HS_POL = 1'b0, VS_POL = 1'b1;
  localparam int   HT = HSW + HB + HA + HF;
  localparam int   VT = VSW + VB + VA + VF;
  localparam int   X0 = HSW + HB;
  localparam int   Y0 = VSW + VB;

  logic        clk = 1'b0, rst = 1'b1;
  logic        hsync = ~HS_POL, vsync = ~VS_POL;
  logic [11:0] pix = '0;
  logic        inj_now = 1'b0;
  logic [1:0]  inj_d = '0;

  logic [10:0] rx_x;
  logic [9:0]  rx_y;
  logic [3:0]  rx_r, rx_g, rx_b;
  logic        rx_de, frame_start, locked, timing_err;
  logic [36:0] outs;

  int checks = 0, failures = 0, fs_cnt = 0, terr_cnt = 0;

  vga_rx_decoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .pix_r(pix[11:8]), .pix_g(pix[7:4]), .pix_b(pix[3:0]),
    .rx_x(rx_x), .rx_y(rx_y), .rx_r(rx_r), .rx_g(rx_g), .rx_b(rx_b),
    .rx_de(rx_de), .frame_start(frame_start), .locked(locked), .timing_err(timing_err)
  );

  assign outs = {locked, timing_err, frame_start, rx_de, rx_x, rx_y, rx_r, rx_g, rx_b};

  always #5 clk = ~clk;

  always @(posedge clk) inj_d <= {inj_d[0], inj_now};

  task automatic chk(input string tag, input logic [36:0] got, input logic [36:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: line position is time since the last hsync leading edge,
  // line number is hsync edges since the frame-anchoring edge.
  int          t = 0, last_hs = 0, lines = 0, mode = 0, gap = 0, pos = 0;
  logic        pend = 0, prev_hs = ~HS_POL, prev_vs = ~VS_POL;
  logic        hl, vl, err, terr, de;
  logic [36:0] exp_now = '0, exp_next = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      t = 0; last_hs = 0; lines = 0; mode = 0; pend = 0;
      prev_hs = ~HS_POL; prev_vs = ~VS_POL;
      exp_now = '0; exp_next = '0;
    end else begin
      exp_now = exp_next;
      t++;
      hl = (hsync == HS_POL) && (prev_hs != HS_POL);
      vl = (vsync == VS_POL) && (prev_vs != VS_POL);
      prev_hs = hsync; prev_vs = vsync;
      gap = t - last_hs;
      err = vl && (lines != VT - 1);
      if (hl) begin
        if (gap != HT) err = 1'b1;
        last_hs = t;
        if (pend || vl)        lines = 0;
        else if (lines < 1023) lines = lines + 1;
        pend = 1'b0;
      end else begin
        if (gap == 2047) err = 1'b1;
        if (vl) pend = 1'b1;
      end
      pos = (t - last_hs > 2047) ? 2047 : t - last_hs;
      terr = 1'b0;
      if (mode != 0 && err) begin
        mode = 0; terr = 1'b1;
      end else if (vl && mode < 2) begin
        mode = mode + 1;
      end
      de = (mode == 2) && pos >= X0 && pos < X0 + HA && lines >= Y0 && lines < Y0 + VA;
      exp_next = {mode == 2, terr, de && pos == X0 && lines == Y0, de,
                  de ? 11'(pos - X0) : 11'd0, de ? 10'(lines - Y0) : 10'd0,
                  de ? pix : 12'd0};
    end
  end

  initial forever begin
    @(negedge clk);
    chk("out", outs, exp_now);
    if (timing_err) begin
      terr_cnt++;
      chk("err_out", 37'({locked, rx_de}), 37'd0);
    end
    if (frame_start) begin
      fs_cnt++;
      chk("fs_pos", 37'({rx_de, rx_x, rx_y}), 37'({1'b1, 21'd0}));
    end
    if (inj_d[1])
      chk("inj", 37'({rx_de, rx_x, rx_y, rx_r, rx_g, rx_b}),
          37'({1'b1, 11'(HA - 1), 10'(VA - 1), 12'h5A3}));
  end

  // vs_off > 0 starts vsync that many clocks before the end of the last line.
  task automatic gen_frame(input int first, input int bad_line, input int bad_len,
                           input int vs_off, input logic inject);
    int len, hw;
    for (int l = first; l < VT; l++) begin
      len = (l == bad_line) ? bad_len : HT;
      hw  = $urandom_range(1, HSW + 2);
      for (int h = 0; h < len; h++) begin
        @(negedge clk);
        hsync = (h < hw) ? HS_POL : ~HS_POL;
        vsync = (l < VSW || (vs_off > 0 && l == VT - 1 && h >= HT - vs_off)) ? VS_POL : ~VS_POL;
        pix = 12'($urandom);
        inj_now = 1'b0;
        if (inject && l == Y0 + VA - 1 && h == X0 + HA - 1) begin
          pix = 12'h5A3;
          inj_now = 1'b1;
        end
      end
    end
  endtask

  task automatic hold_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hsync = ~HS_POL;
      vsync = ~VS_POL;
      pix = 12'($urandom);
      inj_now = 1'b0;
    end
  endtask

  initial begin
    int bl, blen;
    repeat (3) @(negedge clk);
    chk("rst_out", outs, 37'd0);
    rst = 1'b0;

    gen_frame(VT / 2, -1, HT, $urandom_range(0, HT - 1), 1'b0);
    chk("lock_f1", 37'(locked), 37'd0);
    gen_frame(0, -1, HT, $urandom_range(0, HT - 1), 1'b0);
    fs_cnt = 0;
    gen_frame(0, -1, HT, $urandom_range(0, HT - 1), 1'b1);
    chk("lock_f3", 37'(locked), 37'd1);
    chk("fs_f3", 37'(fs_cnt), 37'd1);

    terr_cnt = 0;
    gen_frame(0, 3, HT - 1, $urandom_range(0, HT - 1), 1'b0);
    chk("short_err", 37'(terr_cnt), 37'd1);
    chk("short_unlock", 37'(locked), 37'd0);
    gen_frame(0, -1, HT, 0, 1'b0);
    gen_frame(0, -1, HT, 0, 1'b0);
    chk("relock", 37'(locked), 37'd1);

    terr_cnt = 0;
    hold_idle(2100);
    chk("sat_err", 37'(terr_cnt), 37'd1);
    chk("sat_unlock", 37'(locked), 37'd0);

    gen_frame(0, -1, HT, 0, 1'b0);
    fs_cnt = 0;
    gen_frame(0, -1, HT, 0, 1'b1);
    chk("fs_f8", 37'(fs_cnt), 37'd1);
    chk("lock_f8", 37'(locked), 37'd1);

    fork
      gen_frame(0, -1, HT, 0, 1'b0);
      begin
        repeat ((Y0 + 3) * HT + X0 + 8) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_async", outs, 37'd0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
      end
    join
    gen_frame(0, -1, HT, 0, 1'b0);
    chk("rst_nolock", 37'(locked), 37'd0);
    gen_frame(0, -1, HT, 0, 1'b0);
    chk("rst_relock", 37'(locked), 37'd1);

    for (int f = 0; f < 6; f++) begin
      bl   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, VT - 2)) : -1;
      blen = HT + int'($urandom_range(0, 2)) - 1;
      gen_frame(0, bl, blen, $urandom_range(0, HT - 1), 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
